// File: rtl/pulse_conditioner_if.sv
// pulse_conditioner_if
//   Groups the sensor-side input and the conditioned outputs of
//   pulse_conditioner.
//   master : the conditioner (takes raw_in, drives the conditioned outputs)
//   slave  : the consumer / sensor side (drives raw_in, observes the outputs)
// Signals:
//   raw_in      asynchronous raw sensor line
//   pulse_out   one-cycle strobe per accepted beat
//   sec_tick    one-cycle strobe at the end of each measurement window
//   rate        accepted pulses in the last completed window
//   rate_valid  high once at least one window has completed
//   high_rate   registered (rate >= HIGH_THRESH)
//   overflow    sticky window-counter saturation flag
interface pulse_conditioner_if #(
  parameter int unsigned RATE_W = 14
);
  logic              raw_in;
  logic              pulse_out;
  logic              sec_tick;
  logic [RATE_W-1:0] rate;
  logic              rate_valid;
  logic              high_rate;
  logic              overflow;

  modport master (
    input  raw_in,
    output pulse_out, sec_tick, rate, rate_valid, high_rate, overflow
  );

  modport slave (
    output raw_in,
    input  pulse_out, sec_tick, rate, rate_valid, high_rate, overflow
  );
endinterface

// File: rtl/pulse_conditioner.sv
// pulse_conditioner
//   Synchronises and debounces the raw heartbeat/step line, emits one clean
//   single-cycle pulse per accepted beat with a refractory gap, and measures
//   accepted beats per window.
// Ports:
//   CLK    system clock, rising edge
//   RESET  synchronous, active-low reset
//   bus    pulse_conditioner_if.master:
//            raw_in (in), pulse_out, sec_tick, rate, rate_valid,
//            high_rate, overflow (out, all registered)
module pulse_conditioner #(
  parameter int unsigned TICK_CYCLES     = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned REFRACT_CYCLES  = 20000000,
  parameter int unsigned RATE_W          = 14,
  parameter int unsigned HIGH_THRESH     = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  pulse_conditioner_if.master bus
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned REF_W  = $clog2(REFRACT_CYCLES + 1);
  localparam int unsigned TICK_W = $clog2(TICK_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REF_W-1:0]  REF_LOAD  = REF_W'(REFRACT_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_CHK,
    S_HIGH,
    S_FALL_CHK
  } db_state_e;

  // synchroniser
  logic s1_q, sync_q;

  // debounce FSM
  db_state_e       state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            rise_evt;
  logic            rise_q;

  // refractory / pulse generation
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             acc_q, acc_d;
  logic             pulse_q, pulse_d;

  // window measurement
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [RATE_W-1:0] win_cnt_q, win_cnt_d;
  logic [RATE_W-1:0] win_next;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              tick_end, win_sat;
  logic              sec_tick_q, sec_tick_d;
  logic              rate_valid_q, rate_valid_d;
  logic              high_rate_q, high_rate_d;
  logic              overflow_q, overflow_d;

  // Debounce next-state: a new level must be seen on DEBOUNCE_CYCLES
  // consecutive sync samples; only the accepted rising level yields an event.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    rise_evt = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync_q) begin
          state_d  = S_RISE_CHK;
          db_cnt_d = DB_W'(1);
        end
      end
      S_RISE_CHK: begin
        if (!sync_q) begin
          state_d  = S_LOW;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = S_HIGH;
          db_cnt_d = '0;
          rise_evt = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync_q) begin
          state_d  = S_FALL_CHK;
          db_cnt_d = DB_W'(1);
        end
      end
      S_FALL_CHK: begin
        if (sync_q) begin
          state_d  = S_HIGH;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = S_LOW;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d  = S_LOW;
        db_cnt_d = '0;
      end
    endcase
  end

  // Refractory, pulse and window datapath.
  // The rise event is registered before the refractory check and the accept
  // decision is registered again ahead of pulse_out; together with the
  // synchroniser this fixes the raw-to-pulse latency at DEBOUNCE_CYCLES+3.
  // Window counting uses pulse_d so a pulse rising together with sec_tick
  // lands in the closing window.
  always_comb begin
    acc_d = rise_q && (ref_cnt_q == '0);
    if (acc_d) begin
      ref_cnt_d = REF_LOAD;
    end else if (ref_cnt_q != '0) begin
      ref_cnt_d = ref_cnt_q - REF_W'(1);
    end else begin
      ref_cnt_d = ref_cnt_q;
    end

    pulse_d = acc_q;

    tick_end   = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_end ? '0 : tick_cnt_q + TICK_W'(1);
    sec_tick_d = tick_end;

    win_sat    = (win_cnt_q == '1);
    win_next   = (pulse_d && !win_sat) ? win_cnt_q + RATE_W'(1) : win_cnt_q;
    overflow_d = overflow_q | (pulse_d & win_sat);

    win_cnt_d    = win_next;
    rate_d       = rate_q;
    rate_valid_d = rate_valid_q;
    high_rate_d  = high_rate_q;
    if (tick_end) begin
      win_cnt_d    = '0;
      rate_d       = win_next;
      rate_valid_d = 1'b1;
      high_rate_d  = (32'(win_next) >= HIGH_THRESH);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      s1_q         <= 1'b0;
      sync_q       <= 1'b0;
      state_q      <= S_LOW;
      db_cnt_q     <= '0;
      rise_q       <= 1'b0;
      ref_cnt_q    <= '0;
      acc_q        <= 1'b0;
      pulse_q      <= 1'b0;
      tick_cnt_q   <= '0;
      win_cnt_q    <= '0;
      sec_tick_q   <= 1'b0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      high_rate_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      s1_q         <= bus.raw_in;
      sync_q       <= s1_q;
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      rise_q       <= rise_evt;
      ref_cnt_q    <= ref_cnt_d;
      acc_q        <= acc_d;
      pulse_q      <= pulse_d;
      tick_cnt_q   <= tick_cnt_d;
      win_cnt_q    <= win_cnt_d;
      sec_tick_q   <= sec_tick_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      high_rate_q  <= high_rate_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.pulse_out  = pulse_q;
  assign bus.sec_tick   = sec_tick_q;
  assign bus.rate       = rate_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.high_rate  = high_rate_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: doc/pulse_conditioner.md
Name: pulse_conditioner

Overview:
- Front-end stage that feeds the activity monitor's Pulse input.
- Synchronises and debounces the raw heartbeat/step sensor line, then emits exactly one clean single-cycle pulse per accepted beat.
- Enforces a refractory gap between accepted beats.
- Measures beats per one-second window and flags high-rate windows, so downstream stages count clean events instead of bounce.

Parameters:
- TICK_CYCLES, 100000000: CLK cycles per measurement window (1 s at 100 MHz).
- DEBOUNCE_CYCLES, 1000: consecutive cycles a new level must hold before it is accepted.
- REFRACT_CYCLES, 20000000: cycles after an accepted pulse during which new rising edges are ignored.
- RATE_W, 14: width of the rate count.
- HIGH_THRESH, 64: rate at or above which high_rate asserts.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- raw_in  in  1  asynchronous raw sensor line.
- pulse_out  out  1  one-cycle strobe per accepted beat (drives monitor Pulse).
- sec_tick  out  1  one-cycle strobe at the end of each window.
- rate  out  RATE_W  accepted pulses in the last completed window.
- rate_valid  out  1  high once at least one window has completed.
- high_rate  out  1  registered (rate >= HIGH_THRESH), updated with rate.
- overflow  out  1  sticky; set when the window counter saturates.

Behaviour:
- Reset (RESET==0 at a CLK edge):
  - pulse_out, sec_tick, rate, rate_valid, high_rate, overflow, all counters and the synchroniser flops clear to 0.
  - Debounced level clears to 0; FSM goes to S_LOW.
  - Reset mid-window discards the partial count.
- Synchroniser: 2-flop chain on raw_in; only the second flop (sync) is used downstream.
- Debounce FSM, states S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK:
  - S_LOW: sync==1 -> S_RISE_CHK, db_cnt=1.
  - S_RISE_CHK: sync==0 -> S_LOW, db_cnt=0. Otherwise db_cnt increments; when db_cnt==DEBOUNCE_CYCLES-1 and sync==1 -> S_HIGH, and a rise event fires that cycle.
  - S_HIGH: sync==0 -> S_FALL_CHK, db_cnt=1.
  - S_FALL_CHK: sync==1 -> S_HIGH. Otherwise, after DEBOUNCE_CYCLES consecutive lows -> S_LOW (no event).
  - db_cnt width: clog2(DEBOUNCE_CYCLES)+1.
- Refractory:
  - ref_cnt is nonzero while blocking.
  - A rise event with ref_cnt==0 is accepted: pulse_out=1 on the next cycle (registered), and ref_cnt loads REFRACT_CYCLES-1.
  - ref_cnt decrements to 0 each cycle.
  - A rise event with ref_cnt!=0 is dropped silently.
- Latency: raw_in rising and held stable -> pulse_out high exactly DEBOUNCE_CYCLES+3 CLK edges after the first edge that samples raw_in high. pulse_out is never high two consecutive cycles.
- Window:
  - tick_cnt counts 0..TICK_CYCLES-1 and wraps.
  - On the cycle tick_cnt==TICK_CYCLES-1, sec_tick=1 on the next cycle (registered, aligned with the rate update).
  - At that point rate <= win_cnt + (accepted pulse this cycle ? 1 : 0), saturated. win_cnt <= 0. rate_valid <= 1. high_rate <= (new rate >= HIGH_THRESH).
  - Simultaneous pulse and window end: the pulse counts in the closing window, never in the next.
- Arithmetic:
  - win_cnt is RATE_W bits and saturates at 2^RATE_W-1 (no wrap).
  - An increment attempted at saturation sets overflow; overflow stays 1 until reset.
- Outputs are all registered; no combinational path from raw_in to any output.

Test Plan (TICK_CYCLES=100, DEBOUNCE_CYCLES=4, REFRACT_CYCLES=10, HIGH_THRESH=3, RATE_W=4):
- Reset: hold RESET=0 5 cycles with raw_in toggling -> all outputs 0. Release; first sec_tick exactly 100 cycles later, rate=0, rate_valid=1, high_rate=0.
- Clean pulse: raw_in 0->1 held 20 cycles -> pulse_out high for exactly one cycle, 7 edges after the first high sample. Drop to 0 -> no second pulse.
- Bounce: raw_in high 3 cycles, low 1, high 3, low -> no pulse_out. Then high 4 stable cycles -> exactly one pulse_out.
- Refractory: two clean rising edges 8 cycles apart (accepted-to-rise) -> one pulse_out. Edges 15 cycles apart -> two pulse_out.
- Rate/threshold: 4 accepted pulses in one window -> rate=4, high_rate=1 at that sec_tick. Next window 2 pulses -> rate=2, high_rate=0. Pulse accepted on the cycle tick_cnt==99 -> counted in the closing window.
- Saturation: TICK_CYCLES=1000, REFRACT_CYCLES=1, 20 accepted pulses in one window -> rate=15, overflow=1. overflow still 1 after the next window, and cleared only by RESET.
